reg_file_dump: RTL and testbench
================================

# reg_file_dump

Architectural register file for the KGP-RISC datapath: 32 x 32-bit general registers written by the writeback stage and read by decode, plus a debug dump engine that streams the entire register contents out over a valid/ready port for bench inspection and board-level debug. It is the read-side counterpart of the flip-flop storage layer. It owns all architectural register state; decode reads it combinationally and the debug host drains it word by word.

## Interface

- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: register index width; `2**ADDR_W` registers.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: write enable from writeback.
- `wr_addr`  in  ADDR_W: write index.
- `wr_data`  in  DATA_W: write value.
- `rs_addr`  in  ADDR_W: read port A index.
- `rs_data`  out  DATA_W: read port A value (combinational).
- `rt_addr`  in  ADDR_W: read port B index.
- `rt_data`  out  DATA_W: read port B value (combinational).
- `dump_start`  in  1: one-cycle request to begin a full dump.
- `dump_busy`  out  1: dump in progress.
- `dbg_valid`  out  1: `dbg_data` holds a valid word.
- `dbg_ready`  in  1: host accepts the word this cycle.
- `dbg_data`  out  DATA_W: dumped register value.
- `dbg_idx`  out  ADDR_W: index of the word on `dbg_data`.
- `dbg_last`  out  1: high with the final word (index 31).

## Operation

- Reset (`rst` high at an edge): all 32 registers to 0; FSM to IDLE; `dump_busy`, `dbg_valid`, `dbg_last` to 0; `dbg_data`, `dbg_idx` to 0. Reset wins over every concurrent input, including mid-dump; a dump in progress is aborted with no further words.
- Register 0 reads as 0 always; writes to index 0 are discarded (including in the dump, which emits 0 for index 0).
- Write: when `wr_en` is high at an edge and `wr_addr` != 0, the register takes `wr_data`.
- Read bypass (write-first): if `wr_en` is high and `rs_addr` (or `rt_addr`) equals a nonzero `wr_addr` in the same cycle, the read port returns `wr_data`; otherwise the stored value.
- Dump FSM, states IDLE, STREAM:
  - IDLE: `dump_start` high -> load index 0 into the output register (`dbg_data`=0, `dbg_idx`=0, `dbg_valid`=1), assert `dump_busy`, go STREAM.
  - STREAM: the output word is held stable while `dbg_valid` && !`dbg_ready`. On handshake (`dbg_valid` && `dbg_ready` at an edge) with `dbg_idx` < 31: load index+1 with no bubble. On handshake at index 31: clear `dbg_valid`, `dbg_last`, `dump_busy`; go IDLE.
  - `dump_start` while in STREAM is ignored.
- Loaded dump words use the same write-first bypass as the read ports: a write to the index being loaded in the load cycle is reflected. A write to a register after its word is loaded does not change the presented `dbg_data`.
- `dbg_last` = `dbg_valid` && `dbg_idx`==31, registered with the word.
- Normal reads and writes are never stalled by a dump.

## Timing

- Reads: zero latency, combinational from addresses and write inputs.
- Writes: visible through stored path on the cycle after the edge; same cycle via bypass.
- `dump_start` at edge t -> `dbg_valid`=1, `dbg_idx`=0, `dump_busy`=1 from t+1.
- With `dbg_ready` held high: one word per cycle, indices 0..31 in cycles t+1..t+32; `dump_busy`/`dbg_valid` low from t+33.
- `dump_start` and the last handshake in the same cycle: the start is ignored (FSM not in IDLE at that edge).

## Test plan

- Reset then read: `rst` one cycle, `rs_addr`=5, `rt_addr`=31 -> both 0; dump shows 32 zeros.
- Write/read/bypass: write r7=0xDEADBEEF; same cycle `rs_addr`=7 -> 0xDEADBEEF; next cycle stored read 0xDEADBEEF; write r0=0x1234 -> r0 reads 0.
- Full-rate dump: preload rN=N*0x1111, `dump_start`, `dbg_ready`=1 -> 32 consecutive words idx 0..31, data N*0x1111 (idx 0 -> 0), `dbg_last` only on idx 31, `dump_busy` drops after 32 cycles.
- Backpressure: `dbg_ready` toggling 1,0,0,1 plus a write r3=0xAAAA5555 while idx 3 is held -> `dbg_data`/`dbg_idx` stable while stalled, presented idx-3 word keeps old value, no word skipped or duplicated.
- Ignored start: pulse `dump_start` at idx 10 and in the final handshake cycle -> dump continues unchanged, no second dump begins.
- Reset mid-dump: assert `rst` at idx 12 -> next cycle `dbg_valid`=0, `dump_busy`=0, all registers 0; a new `dump_start` restarts at idx 0.

Source files
------------

// File: rtl/reg_file_dump.sv
// KGP-RISC architectural register file with write-first read ports
// and a valid/ready debug engine that streams all registers out.
module reg_file_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dbg_valid,
    input  logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W-1:0] dbg_idx,
    output logic              dbg_last
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    localparam logic IDLE   = 1'b0;
    localparam logic STREAM = 1'b1;

    logic [DATA_W-1:0] regs [NREG];
    logic              state;

    logic              wr_hit;
    logic              hshake;
    logic              load_en;
    logic              done;
    logic [ADDR_W-1:0] load_idx;
    logic [DATA_W-1:0] load_val;

    assign wr_hit = wr_en && (wr_addr != '0);

    // Register 0 is hardwired: never written, so it never needs bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wr_hit && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wr_hit && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end
    end

    assign hshake  = (state == STREAM) && dbg_ready;
    assign done    = hshake && (dbg_idx == LAST_IDX);
    assign load_en = ((state == IDLE) && dump_start)
                   || (hshake && (dbg_idx != LAST_IDX));

    always_comb begin
        load_idx = '0;
        if (state == STREAM) begin
            load_idx = dbg_idx + ADDR_W'(1);
        end
    end

    // The word is captured with the same write-first view as the read ports.
    always_comb begin
        load_val = regs[load_idx];
        if (load_idx == '0) begin
            load_val = '0;
        end else if (wr_hit && (wr_addr == load_idx)) begin
            load_val = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dbg_data <= '0;
            dbg_idx  <= '0;
            dbg_last <= 1'b0;
        end else begin
            if (load_en) begin
                state    <= STREAM;
                dbg_data <= load_val;
                dbg_idx  <= load_idx;
                dbg_last <= (load_idx == LAST_IDX);
            end else if (done) begin
                state    <= IDLE;
                dbg_last <= 1'b0;
            end
        end
    end

    assign dbg_valid = (state == STREAM);
    assign dump_busy = (state == STREAM);

endmodule

// File: tb/tb_reg_file_dump.sv
// Randomized and directed bench for reg_file_dump against a
// behavioural model of the register array and the dump stream.
module tb_reg_file_dump;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs_addr;
    logic [31:0] rs_data;
    logic [4:0]  rt_addr;
    logic [31:0] rt_data;
    logic        dump_start;
    logic        dump_busy;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [31:0] dbg_data;
    logic [4:0]  dbg_idx;
    logic        dbg_last;

    reg_file_dump #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rs_addr(rs_addr),
        .rs_data(rs_data),
        .rt_addr(rt_addr),
        .rt_data(rt_data),
        .dump_start(dump_start),
        .dump_busy(dump_busy),
        .dbg_valid(dbg_valid),
        .dbg_ready(dbg_ready),
        .dbg_data(dbg_data),
        .dbg_idx(dbg_idx),
        .dbg_last(dbg_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: register contents plus the word the dump is presenting.
    logic [31:0] mem [32];
    bit          m_busy;
    int          m_idx;
    logic [31:0] m_data;
    bit          m_rst;
    bit          chk_on;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_exp(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return mem[a];
    endfunction

    task automatic drive(input logic r, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic s, input logic rdy);
        rst        = r;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        rs_addr    = ra;
        rt_addr    = rb;
        dump_start = s;
        dbg_ready  = rdy;
        #3;
    endtask

    task automatic adv();
        if (chk_on) begin
            chk("rs_data", rs_data, rd_exp(rs_addr));
            chk("rt_data", rt_data, rd_exp(rt_addr));
            chk("dbg_valid", 32'(dbg_valid), 32'(m_busy));
            chk("dump_busy", 32'(dump_busy), 32'(m_busy));
            chk("dbg_last", 32'(dbg_last), 32'(m_busy && m_idx == 31));
            if (m_busy || m_rst) begin
                chk("dbg_idx", 32'(dbg_idx), 32'(m_idx));
                chk("dbg_data", dbg_data, m_data);
            end
            m_rst = 0;
        end
        if (rst) begin
            foreach (mem[i]) mem[i] = 32'h0;
            m_busy = 0;
            m_idx  = 0;
            m_data = 32'h0;
            m_rst  = 1;
        end else begin
            if (wr_en && wr_addr != 0) mem[wr_addr] = wr_data;
            if (!m_busy) begin
                if (dump_start) begin
                    m_busy = 1;
                    m_idx  = 0;
                    m_data = mem[0];
                end
            end else if (dbg_ready) begin
                if (m_idx == 31) begin
                    m_busy = 0;
                end else begin
                    m_idx  = m_idx + 1;
                    m_data = mem[m_idx];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic s, input logic rdy);
        drive(r, we, wa, wd, ra, rb, s, rdy);
        adv();
    endtask

    task automatic run_to(input int idx);
        int g = 0;
        while (m_busy && m_idx != idx && g < 40) begin
            step(0, 0, 0, 0, 5'(g), 5'(31 - g), 0, 1);
            g++;
        end
        chk("reach_idx", 32'(dbg_idx), 32'(idx));
    endtask

    initial begin
        int n;
        foreach (mem[i]) mem[i] = 32'h0;
        m_busy = 0; m_idx = 0; m_data = 0; m_rst = 0;
        chk_on = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_on = 1;

        // reset state and an all-zero dump
        drive(0, 0, 0, 0, 5, 31, 0, 0);
        chk("rst_rs", rs_data, 32'h0);
        chk("rst_rt", rt_data, 32'h0);
        adv();
        step(0, 0, 0, 0, 0, 0, 1, 1);
        n = 0;
        while (m_busy && n < 40) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            n++;
        end
        chk("zero_dump_len", 32'(n), 32'd32);

        // write, bypass, stored read, r0 discard
        drive(0, 1, 7, 32'hDEADBEEF, 7, 0, 0, 0);
        chk("byp_r7", rs_data, 32'hDEADBEEF);
        adv();
        drive(0, 1, 0, 32'h1234, 0, 7, 0, 0);
        chk("stored_r7", rt_data, 32'hDEADBEEF);
        chk("r0_same", rs_data, 32'h0);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_after", rs_data, 32'h0);
        adv();

        // preload rN = N*0x1111 and dump at full rate
        for (int i = 1; i < 32; i++)
            step(0, 1, 5'(i), 32'(i * 32'h1111), 5'(i - 1), 5'(i), 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        n = 0;
        while (m_busy && n < 40) begin
            if (n == 31) chk("last_word", dbg_data, 32'(31 * 32'h1111));
            step(0, 0, 0, 0, 5'(n), 5'(n + 1), 0, 1);
            n++;
        end
        chk("full_dump_len", 32'(n), 32'd32);

        // backpressure with a write to the held word's register
        step(0, 0, 0, 0, 0, 0, 1, 1);
        run_to(3);
        step(0, 1, 3, 32'hAAAA5555, 3, 0, 0, 0);
        drive(0, 0, 0, 0, 3, 0, 0, 0);
        chk("held_idx", 32'(dbg_idx), 32'd3);
        chk("held_data", dbg_data, 32'h3333);
        adv();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("after_hold", 32'(dbg_idx), 32'd4);
        n = 0;
        while (m_busy && n < 100) begin
            step(0, 0, 0, 0, 0, 0, 0, n[0]);
            n++;
        end

        // start pulses ignored during a dump
        step(0, 0, 0, 0, 0, 0, 1, 1);
        run_to(10);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        chk("ign_start", 32'(dbg_idx), 32'd11);
        run_to(31);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("no_restart", 32'(dump_busy), 32'd0);
        adv();

        // reset mid-dump then restart
        step(0, 0, 0, 0, 0, 0, 1, 1);
        run_to(12);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 3, 7, 0, 1);
        chk("mid_rst_valid", 32'(dbg_valid), 32'd0);
        chk("mid_rst_r7", rt_data, 32'h0);
        adv();
        step(0, 0, 0, 0, 0, 0, 1, 1);
        chk("restart_idx", 32'(dbg_idx), 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(199) == 0,
                 1'($urandom),
                 5'($urandom),
                 $urandom,
                 5'($urandom),
                 5'($urandom),
                 $urandom_range(15) == 0,
                 $urandom_range(9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
